// File: rtl/lock_input_cond.sv
// Input conditioning for the combination lock: synchronizes and debounces the
// four combination switches, decodes thermometer progress, generates the 1 s
// tick and flags a stalled partial entry.
// Optional stall timeout is built when LOCK_IN_TIMEOUT_EN is defined; without
// it TIMEOUT is tied low and no timeout counter exists.
module lock_input_cond #(
  parameter int DEB_CYCLES    = 1000000,
  parameter int TICK_DIV      = 50000000,
  parameter int TIMEOUT_TICKS = 30
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic [3:0] SW_IN,
  output logic [3:0] SW_STABLE,
  output logic [3:0] SW_RISE,
  output logic [2:0] STEP,
  output logic       STEP_VALID,
  output logic       TICK_1S,
  output logic       TIMEOUT
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int TW = $clog2(TICK_DIV + 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [3:0]    sync1_q, sync2_q;
  logic [3:0]    stable_q, stable_d, stable_prev_q;
  logic [DW-1:0] deb_cnt_q [4];
  logic [DW-1:0] deb_cnt_d [4];
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;

  // Two-flop synchronizer: SW_IN is asynchronous to CLOCK_50.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= SW_IN;
      sync2_q <= sync1_q;
    end
  end

  // Per-bit debounce: count consecutive disagreeing cycles, adopt on the last one.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 4; i++) begin
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
        end
      end
    end
  end

  // Debounce state, previous stable value for edge detect, and the tick divider.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < 4; i++) deb_cnt_q[i] <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      tick_cnt_q    <= '0;
    end else begin
      for (int i = 0; i < 4; i++) deb_cnt_q[i] <= deb_cnt_d[i];
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      tick_cnt_q    <= tick_cnt_d;
    end
  end

  // Free-running divider; TICK_1S marks the last count of each period.
  always_comb begin
    TICK_1S    = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = TICK_1S ? '0 : tick_cnt_q + TW'(1);
  end

  assign SW_STABLE = stable_q;
  assign SW_RISE   = stable_q & ~stable_prev_q;

  // Thermometer decode of the stable switches into combination progress.
  always_comb begin
    STEP       = 3'd0;
    STEP_VALID = 1'b1;
    case (stable_q)
      4'b0000: STEP = 3'd0;
      4'b1000: STEP = 3'd1;
      4'b1100: STEP = 3'd2;
      4'b1110: STEP = 3'd3;
      4'b1111: STEP = 3'd4;
      default: begin
        STEP       = 3'd0;
        STEP_VALID = 1'b0;
      end
    endcase
  end

`ifdef LOCK_IN_TIMEOUT_EN
  localparam int OW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [OW-1:0] TO_LAST = OW'(TIMEOUT_TICKS - 1);

  logic [2:0]    step_prev_q;
  logic [OW-1:0] to_cnt_q, to_cnt_d;
  logic          to_fire;

  // Stall counter: any progress change or non-partial state restarts it,
  // taking precedence over a coincident tick.
  always_comb begin
    to_cnt_d = to_cnt_q;
    to_fire  = 1'b0;
    if ((STEP != step_prev_q) || !STEP_VALID || (STEP == 3'd0) || (STEP == 3'd4)) begin
      to_cnt_d = '0;
    end else if (TICK_1S) begin
      if (to_cnt_q == TO_LAST) begin
        to_cnt_d = '0;
        to_fire  = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + OW'(1);
      end
    end
  end

  // Stall counter and last-cycle progress for change detection.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      to_cnt_q    <= '0;
      step_prev_q <= 3'd0;
    end else begin
      to_cnt_q    <= to_cnt_d;
      step_prev_q <= STEP;
    end
  end

  assign TIMEOUT = to_fire;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_TICKS != 0);
  assign TIMEOUT = 1'b0;
`endif

endmodule

// File: doc/lock_input_cond.md
LOCK_INPUT_COND -- requirements
Module: lock_input_cond

Interface
REQ-001 Parameter DEB_CYCLES, default 1000000, consecutive cycles a synchronized switch must differ from its stable value before the stable value updates (20 ms at 50 MHz).
REQ-002 Parameter TICK_DIV, default 50000000, clock cycles per TICK_1S pulse.
REQ-003 Parameter TIMEOUT_TICKS, default 30, TICK_1S pulses without progress before TIMEOUT fires.
REQ-004 CLOCK_50  input  1  sole clock, all state on its rising edge.
REQ-005 RESET_N  input  1  reset, asynchronous, active-low.
REQ-006 SW_IN  input  4  raw combination switches, bit3=SW[9], bit0=SW[6], asynchronous to CLOCK_50.
REQ-007 SW_STABLE  output  4  debounced switch levels.
REQ-008 SW_RISE  output  4  one-cycle pulse per bit on a 0->1 change of SW_STABLE.
REQ-009 STEP  output  3  combination progress, 0..4.
REQ-010 STEP_VALID  output  1  SW_STABLE is a legal thermometer pattern.
REQ-011 TICK_1S  output  1  one-cycle pulse every TICK_DIV cycles, feeds the downstream lock FSM.
REQ-012 TIMEOUT  output  1  one-cycle pulse, stalled partial entry, drives the downstream lock reset.

Function
REQ-013 Each SW_IN bit SHALL pass through a two-flop synchronizer before any other use.
REQ-014 Per bit, a debounce counter SHALL clear whenever the synchronized bit equals SW_STABLE, and otherwise increment.
REQ-015 SW_STABLE bit SHALL take the synchronized value on the edge where its counter would reach DEB_CYCLES; the counter then clears; total latency is 2+DEB_CYCLES cycles from SW_IN change.
REQ-016 A glitch shorter than DEB_CYCLES cycles SHALL leave SW_STABLE unchanged.
REQ-017 SW_RISE[i] SHALL be high exactly in the first cycle SW_STABLE[i] reads 1 after reading 0; falls produce no pulse.
REQ-018 STEP/STEP_VALID SHALL decode SW_STABLE combinationally: 0000->0, 1000->1, 1100->2, 1110->3, 1111->4, all with STEP_VALID=1; any other pattern -> STEP=0, STEP_VALID=0.
REQ-019 A tick counter SHALL count 0..TICK_DIV-1 and wrap; TICK_1S high in the cycle the counter equals TICK_DIV-1; free-running, never gated.
REQ-020 Timeout counter SHALL increment on TICK_1S while STEP_VALID=1 and STEP in 1..3.
REQ-021 Timeout counter SHALL clear when STEP changes, STEP_VALID=0, or STEP is 0 or 4.
REQ-022 If STEP changes and TICK_1S occur in the same cycle, clear SHALL win.
REQ-023 When the counter would reach TIMEOUT_TICKS, TIMEOUT SHALL pulse for one cycle and the counter SHALL clear; TIMEOUT repeats every TIMEOUT_TICKS ticks while stall persists.
REQ-024 All counters SHALL be sized to hold their parameter value without wrap-around.

Reset
REQ-025 RESET_N low SHALL immediately clear synchronizers, debounce counters, tick and timeout counters; SW_STABLE=0000, SW_RISE=0, TICK_1S=0, TIMEOUT=0, STEP=0, STEP_VALID=1.
REQ-026 Reset assertion mid-debounce or mid-tick SHALL discard partial counts; after release the first TICK_1S occurs TICK_DIV cycles later.
REQ-027 Switches already high at reset release SHALL produce SW_RISE after 2+DEB_CYCLES cycles.

Configuration
REQ-028 Macro LOCK_IN_TIMEOUT_EN defined: timeout counter and REQ-020..023 implemented.
REQ-029 Macro LOCK_IN_TIMEOUT_EN undefined: no timeout counter synthesized, TIMEOUT tied 0; all other behaviour identical.

Verification (DEB_CYCLES=4, TICK_DIV=10, TIMEOUT_TICKS=3, macro defined unless noted)
REQ-030 SW_IN 0000->1000 held -> SW_STABLE=1000 and SW_RISE=1000 for one cycle exactly 6 cycles later; STEP=1.
REQ-031 SW_IN bit3 high for 3 cycles then low -> SW_STABLE stays 0000, no SW_RISE.
REQ-032 Walk 1000,1100,1110,1111 with settled holds -> STEP 1,2,3,4, STEP_VALID=1; SW_IN 0100 -> STEP=0, STEP_VALID=0.
REQ-033 Hold STEP=2 -> TIMEOUT pulses on the 3rd TICK_1S, again on the 6th; change to STEP=3 on a tick cycle -> count restarts, no pulse.
REQ-034 RESET_N low for 1 cycle mid-debounce and at tick count 7 -> all outputs reset values, next TICK_1S 10 cycles after release.
REQ-035 Macro undefined, stall at STEP=2 for 10 ticks -> TIMEOUT stays 0.
